// File: rtl/out_arb_pkg.sv
// Shared types and default sizing for the output-device round-robin arbiter.
package out_arb_pkg;

   localparam int N_REQ_DEF     = 4;
   localparam int BURST_LEN_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_START,
      ST_ACK,
      ST_WAIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/out_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: starting one past ptr and wrapping,
// returns the first eligible requester. ptr itself has lowest priority.
module rr_picker #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [2:0]       ptr,
   output logic [2:0]       index,
   output logic             valid
);

   // Walk candidates from farthest to nearest so the nearest hit wins.
   always_comb begin
      index = '0;
      valid = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         for (int i = 0; i < N_REQ; i++) begin
            if ((((int'(ptr) + k) % N_REQ) == i) && eligible[i]) begin
               index = 3'(i);
               valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/out_rr_arbiter.sv
// Round-robin arbiter moving bytes from N_REQ FWFT FIFOs to one output device.
// Each grant reads one byte, raises out_start, waits for the device to go
// busy (out_finish=0) and then idle again, and pulses byte_done.
// Optional burst mode: define OUT_ARB_BURST_EN to let a grant move up to
// BURST_LEN consecutive bytes without re-arbitrating.
module out_rr_arbiter
   import out_arb_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [N_REQ-1:0]   fifo_empty,
   input  logic [N_REQ-1:0]   fifo_busy,
   input  logic [8*N_REQ-1:0] fifo_data,
   output logic [N_REQ-1:0]   fifo_re,
   output logic [7:0]         out_data,
   output logic               out_start,
   input  logic               out_finish,
   output logic [2:0]         grant,
   output logic               idle,
   output logic               byte_done
);

   state_t           state, state_next;
   logic [2:0]       ptr;
   logic [N_REQ-1:0] eligible;
   logic [2:0]       pick_index;
   logic             pick_valid;
   logic [7:0]       sel_byte;

   assign eligible = ~fifo_empty & ~fifo_busy;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .eligible (eligible),
      .ptr      (ptr),
      .index    (pick_index),
      .valid    (pick_valid)
   );

   // Byte currently presented by the granted FIFO.
   always_comb begin
      sel_byte = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant == 3'(i)) sel_byte = fifo_data[8*i +: 8];
   end

`ifdef OUT_ARB_BURST_EN
   logic [3:0] burst_cnt;
   logic       grant_eligible;
   logic       burst_more;

   // Is the current grant holder still able to supply another byte?
   always_comb begin
      grant_eligible = 1'b0;
      for (int i = 0; i < N_REQ; i++)
         if (grant == 3'(i)) grant_eligible = eligible[i];
   end

   assign burst_more = (burst_cnt < 4'(BURST_LEN)) && grant_eligible;
`endif

   // Next-state logic for the transfer sequence.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  if (enable && out_finish && pick_valid) state_next = ST_READ;
         ST_READ:  state_next = ST_START;
         ST_START: state_next = ST_ACK;
         ST_ACK:   if (!out_finish) state_next = ST_WAIT;
         ST_WAIT:  if (out_finish) state_next = ST_DONE;
         ST_DONE: begin
`ifdef OUT_ARB_BURST_EN
            state_next = burst_more ? ST_READ : ST_IDLE;
`else
            state_next = ST_IDLE;
`endif
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   // State, grant/pointer bookkeeping and output byte capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         ptr      <= 3'(N_REQ - 1);
         grant    <= '0;
         out_data <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && state_next == ST_READ) grant <= pick_index;
         if (state == ST_READ) out_data <= sel_byte;
         // Pointer only advances when the grant is released.
         if (state == ST_DONE && state_next == ST_IDLE) ptr <= grant;
      end
   end

`ifdef OUT_ARB_BURST_EN
   // Bytes moved under the current grant, including the one in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         burst_cnt <= '0;
      end else if (state == ST_IDLE && state_next == ST_READ) begin
         burst_cnt <= 4'd1;
      end else if (state == ST_DONE) begin
         burst_cnt <= burst_more ? burst_cnt + 4'd1 : 4'd0;
      end
   end
`endif

   // Strobes decoded from state; read strobe is one-hot on the grant.
   always_comb begin
      fifo_re = '0;
      for (int i = 0; i < N_REQ; i++)
         fifo_re[i] = (state == ST_READ) && (grant == 3'(i));
   end

   assign out_start = (state == ST_START) || (state == ST_ACK);
   assign idle      = (state == ST_IDLE);
   assign byte_done = (state == ST_DONE);

endmodule

// File: tb/tb_out_rr_arbiter.sv
// Directed bench for out_rr_arbiter: FIFO and device models, a vector table
// of single-byte arbitration cases, and hand sequences for multi-cycle cases.
module tb_out_rr_arbiter;

   localparam int NR = 4;
   localparam int BL = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic [NR-1:0]   fifo_empty, fifo_busy, fifo_re;
   logic [8*NR-1:0] fifo_data;
   logic [7:0]      out_data;
   logic            out_start, out_finish, idle, byte_done;
   logic [2:0]      grant;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   out_rr_arbiter #(.N_REQ(NR), .BURST_LEN(BL)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_busy(fifo_busy), .fifo_data(fifo_data),
      .fifo_re(fifo_re), .out_data(out_data), .out_start(out_start),
      .out_finish(out_finish), .grant(grant), .idle(idle), .byte_done(byte_done)
   );

   // ---------------- FIFO model (ring of 16 per requester) ----------------
   logic [7:0] mem [NR][16];
   int         rd [NR];
   int         wr [NR];
   logic [NR-1:0] re_q;

   for (genvar g = 0; g < NR; g++) begin : g_fifo
      assign fifo_empty[g]      = (rd[g] == wr[g]);
      assign fifo_data[8*g +: 8] = mem[g][rd[g][3:0]];
   end

   // Pop after the edge that ends the read cycle.
   always @(posedge clk) begin
      re_q = fifo_re;
      #1;
      for (int i = 0; i < NR; i++)
         if (re_q[i] && rd[i] != wr[i]) rd[i] = rd[i] + 1;
   end

   task automatic push(input int i, input logic [7:0] b);
      mem[i][wr[i][3:0]] = b;
      wr[i] = wr[i] + 1;
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < NR; i++) wr[i] = rd[i];
   endtask

   // ---------------- Output device model ----------------
   int ack_delay = 0;
   int busy_len  = 2;
   int dph = 0;
   int dcnt = 0;

   always @(negedge clk) begin
      if (reset) begin
         dph = 0; dcnt = 0; out_finish = 1'b1;
      end else begin
         case (dph)
            0: if (out_start) begin dcnt = ack_delay; dph = 1; end
            1: if (dcnt == 0) begin out_finish = 1'b0; dcnt = busy_len; dph = 2; end
               else dcnt = dcnt - 1;
            default: if (dcnt == 0) begin out_finish = 1'b1; dph = 0; end
               else dcnt = dcnt - 1;
         endcase
      end
   end

   // ---------------- Monitor ----------------
   int re_cnt = 0;
   int done_cnt = 0;
   int multi_re = 0;
   int re_log [64];
   int done_glog [64];

   always @(negedge clk) begin
      if ($countones(fifo_re) > 1) multi_re = multi_re + 1;
      if (fifo_re != '0) begin
         for (int i = 0; i < NR; i++)
            if (fifo_re[i]) re_log[re_cnt % 64] = i;
         re_cnt = re_cnt + 1;
      end
      if (byte_done) begin
         done_glog[done_cnt % 64] = int'(grant);
         done_cnt = done_cnt + 1;
      end
   end

   // ---------------- Helpers ----------------
   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_done(input int target, input int budget, input string nm);
      int k = 0;
      while (done_cnt < target && k < budget) begin step(); k++; end
      chk({nm, "_done_reached"}, 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int k = 0;
      while (!idle && k < budget) begin step(); k++; end
      chk({nm, "_idle"}, 32'(idle), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; fifo_busy = '0;
      ack_delay = 0; busy_len = 2;
      clear_fifos();
      repeat (2) step();
      reset = 1'b0;
      step();
   endtask

   typedef struct {
      logic [3:0] have;
      logic [3:0] busy;
      logic       en;
      logic       fire;
      logic [2:0] g;
      logic [7:0] data;
   } vec_t;

   vec_t tbl [10];
   int   exp38 [5];
   int   exp41 [12];

   initial begin
      int r0, d0, k, lowc, bad_re;

      for (int i = 0; i < NR; i++)
         for (int j = 0; j < 16; j++) mem[i][j] = 8'h00;
      fifo_busy = '0;

      // Requester i always offers 8'hA3+i in the table.
      // Pointer is 2 when the table starts (last grant was requester 2).
      tbl[0] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 3'd2, 8'hA5};
      tbl[1] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0, 8'h00};
      tbl[2] = '{4'b1111, 4'b1000, 1'b1, 1'b1, 3'd0, 8'hA3};
      tbl[3] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 3'd0, 8'hA3};
      tbl[4] = '{4'b1011, 4'b0010, 1'b1, 1'b1, 3'd3, 8'hA6};
      tbl[5] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 8'h00};
      tbl[6] = '{4'b0110, 4'b0110, 1'b1, 1'b0, 3'd0, 8'h00};
      tbl[7] = '{4'b0110, 4'b0000, 1'b1, 1'b1, 3'd1, 8'hA4};
      tbl[8] = '{4'b1110, 4'b0000, 1'b1, 1'b1, 3'd2, 8'hA5};
      tbl[9] = '{4'b0011, 4'b0000, 1'b1, 1'b1, 3'd0, 8'hA3};

`ifdef OUT_ARB_BURST_EN
      exp38 = '{0, 0, 1, 1, 2};
`else
      exp38 = '{0, 1, 2, 3, 0};
`endif
      exp41 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

      // ---- reset state ----
      reset = 1'b1;
      repeat (3) step();
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_fifo_re", 32'(fifo_re), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_start", 32'(out_start), 32'd0);
      chk("rst_byte_done", 32'(byte_done), 32'd0);
      reset = 1'b0;
      step();

      // ---- single requester 2 with 0xA5: read strobe, latency, data ----
      push(2, 8'hA5);
      enable = 1'b1;
      k = 0;
      while (fifo_re == '0 && k < 20) begin step(); k++; end
      chk("a5_re_seen", 32'(fifo_re != '0), 32'd1);
      chk("a5_re_bit", 32'(fifo_re), 32'h4);
      chk("a5_grant", 32'(grant), 32'd2);
      chk("a5_start_in_read", 32'(out_start), 32'd0);
      step();
      chk("a5_start", 32'(out_start), 32'd1);
      chk("a5_re_clear", 32'(fifo_re), 32'd0);
      chk("a5_data", 32'(out_data), 32'hA5);
      wait_done(1, 40, "a5");
      enable = 1'b0;
      repeat (3) step();
      chk("a5_done_cnt", 32'(done_cnt), 32'd1);
      chk("a5_re_cnt", 32'(re_cnt), 32'd1);
      chk("a5_done_grant", 32'(done_glog[0]), 32'd2);
      chk("a5_back_idle", 32'(idle), 32'd1);

      // ---- vector table: one arbitration each ----
      for (int v = 0; v < 10; v++) begin
         clear_fifos();
         fifo_busy = tbl[v].busy;
         for (int i = 0; i < NR; i++)
            if (tbl[v].have[i]) push(i, 8'hA3 + 8'(i));
         r0 = re_cnt; d0 = done_cnt;
         enable = tbl[v].en;
         for (int c = 0; c < 25; c++) begin
            step();
            if (done_cnt > d0) enable = 1'b0;
         end
         enable = 1'b0;
         step();
         chk($sformatf("vec%0d_reads", v), 32'(re_cnt - r0), 32'(tbl[v].fire));
         chk($sformatf("vec%0d_dones", v), 32'(done_cnt - d0), 32'(tbl[v].fire));
         chk($sformatf("vec%0d_idle", v), 32'(idle), 32'd1);
         if (tbl[v].fire) begin
            chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(tbl[v].g));
            chk($sformatf("vec%0d_data", v), 32'(out_data), 32'(tbl[v].data));
         end
      end
      fifo_busy = '0;

      // ---- all four eligible: grant order from reset ----
      do_reset();
      for (int i = 0; i < NR; i++) begin
         push(i, 8'h10 * 8'(i));
         push(i, 8'h10 * 8'(i) + 8'h1);
      end
      r0 = re_cnt; d0 = done_cnt;
      enable = 1'b1;
      wait_done(d0 + 5, 120, "rr");
      enable = 1'b0;
      wait_idle(60, "rr");
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("rr_read%0d", j), 32'(re_log[r0 + j]), 32'(exp38[j]));
         chk($sformatf("rr_done%0d", j), 32'(done_glog[d0 + j]), 32'(exp38[j]));
      end

      // ---- device stays busy 20 cycles ----
      clear_fifos();
      push(1, 8'h5A);
      busy_len = 20;
      r0 = re_cnt; d0 = done_cnt;
      enable = 1'b1;
      k = 0;
      while (out_finish && k < 20) begin step(); k++; end
      chk("long_ack_seen", 32'(out_finish), 32'd0);
      lowc = 0; bad_re = 0;
      while (!out_finish && lowc < 40) begin
         if (fifo_re != '0) bad_re++;
         step();
         lowc++;
      end
      chk("long_low_cycles", 32'(lowc), 32'd21);
      chk("long_no_read", 32'(bad_re), 32'd0);
      chk("long_no_early_done", 32'(done_cnt - d0), 32'd0);
      wait_done(d0 + 1, 10, "long");
      enable = 1'b0;
      repeat (3) step();
      chk("long_one_done", 32'(done_cnt - d0), 32'd1);
      chk("long_one_read", 32'(re_cnt - r0), 32'd1);
      chk("long_grant", 32'(done_glog[d0]), 32'd1);
      busy_len = 2;

      // ---- enable low blocks grants ----
      clear_fifos();
      for (int i = 0; i < NR; i++) push(i, 8'h30 + 8'(i));
      r0 = re_cnt; d0 = done_cnt;
      enable = 1'b0;
      repeat (10) step();
      chk("en0_no_read", 32'(re_cnt - r0), 32'd0);
      chk("en0_idle", 32'(idle), 32'd1);

      // ---- enable dropped in WAIT: byte completes, then idle ----
      enable = 1'b1;
      k = 0;
      while (!(out_finish == 1'b0 && out_start == 1'b0) && k < 30) begin step(); k++; end
      chk("endrop_in_wait", 32'(!out_finish && !out_start), 32'd1);
      enable = 1'b0;
      wait_done(d0 + 1, 20, "endrop");
      repeat (10) step();
      chk("endrop_reads", 32'(re_cnt - r0), 32'd1);
      chk("endrop_dones", 32'(done_cnt - d0), 32'd1);
      chk("endrop_idle", 32'(idle), 32'd1);

      // ---- reset during ACK clears pointer ----
      do_reset();
      push(1, 8'h41);
      enable = 1'b1;
      wait_done(done_cnt + 1, 40, "pre_ack");
      enable = 1'b0;
      wait_idle(10, "pre_ack");
      push(2, 8'h42);
      ack_delay = 10;
      enable = 1'b1;
      k = 0;
      while (!out_start && k < 20) begin step(); k++; end
      step();
      chk("ack_holding", 32'(out_start), 32'd1);
      reset = 1'b1;
      step();
      chk("ackrst_start", 32'(out_start), 32'd0);
      chk("ackrst_idle", 32'(idle), 32'd1);
      chk("ackrst_re", 32'(fifo_re), 32'd0);
      chk("ackrst_grant", 32'(grant), 32'd0);
      reset = 1'b0;
      ack_delay = 0;
      clear_fifos();
      for (int i = 0; i < NR; i++) push(i, 8'h50 + 8'(i));
      step();
      k = 0;
      while (fifo_re == '0 && k < 20) begin step(); k++; end
      chk("ackrst_next_re", 32'(fifo_re), 32'h1);
      chk("ackrst_next_grant", 32'(grant), 32'd0);
      enable = 1'b0;
      wait_idle(40, "ackrst");

`ifdef OUT_ARB_BURST_EN
      // ---- burst: two requesters with six bytes each ----
      do_reset();
      for (int j = 0; j < 6; j++) begin
         push(0, 8'h60 + 8'(j));
         push(1, 8'h70 + 8'(j));
      end
      r0 = re_cnt; d0 = done_cnt;
      enable = 1'b1;
      wait_done(d0 + 12, 400, "burst");
      enable = 1'b0;
      wait_idle(40, "burst");
      for (int j = 0; j < 12; j++)
         chk($sformatf("burst_read%0d", j), 32'(re_log[r0 + j]), 32'(exp41[j]));
      chk("burst_total", 32'(re_cnt - r0), 32'd12);
`endif

      chk("onehot_re", 32'(multi_re), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
